// File: rtl/cell_tb_pkg.sv
// Shared types, reference truth tables and lookup helper for the cell sweep checker.
// Truth table bit i is the expected cell output when input vector i is applied.
package cell_tb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_W,
        SAMPLE,
        FINISH
    } sweep_state_t;

    // OAI221 vector = {A,B1,B2,C1,C2}; AOI21 vector = {A1,A2,B}; 2-input cells vector = {A,B}
    localparam logic [31:0] TT_OAI221 = 32'h111F_FFFF;
    localparam logic [7:0]  TT_AOI21  = 8'h15;
    localparam logic [3:0]  TT_NAND2  = 4'b0111;
    localparam logic [3:0]  TT_NOR2   = 4'b0001;
    localparam logic [3:0]  TT_AND2   = 4'b1000;

    function automatic logic tt_bit(input logic [255:0] tt, input logic [7:0] vec);
        return tt[vec];
    endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Loadable down-counter that parks at zero; zero flag marks the end of the settle wait.
module sweep_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cell_sweep_checker.sv
// Exhaustive truth-table sweeper: walks every input vector of a combinational cell,
// waits SETTLE cycles, samples the output and accumulates mismatches against EXP_TT.
module cell_sweep_checker
    import cell_tb_pkg::*;
#(
    parameter int                 N_IN   = 5,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXP_TT = TT_OAI221
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            stop_on_err,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid,
    output logic            smp_valid,
    output logic [N_IN-1:0] smp_vec,
    output logic            smp_val
);

    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);
    localparam logic [N_IN:0]   ERR_MAX  = {1'b1, {N_IN{1'b0}}};
    localparam logic [255:0]    TT_FULL  = 256'(EXP_TT);

    sweep_state_t state, state_nxt;
    logic         stop_lat, aborted;
    logic         cnt_load, cnt_dec, cnt_zero;
    logic         mismatch, last_vec, go;

    assign mismatch = (dut_out != tt_bit(TT_FULL, 8'(dut_in)));
    assign last_vec = (dut_in == '1);
    assign go       = start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = SETTLE_W;
                    cnt_load  = 1'b1;
                end
            end
            SETTLE_W: begin
                cnt_dec = !cnt_zero;
                if (abort)
                    state_nxt = FINISH;
                else if (cnt_zero)
                    state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (abort || last_vec || (stop_lat && mismatch)) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = SETTLE_W;
                    cnt_load  = 1'b1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    sweep_settle_cnt #(.W(CW)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            smp_valid       <= 1'b0;
            smp_vec         <= '0;
            smp_val         <= 1'b0;
            stop_lat        <= 1'b0;
            aborted         <= 1'b0;
        end else begin
            done      <= 1'b0;
            smp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        pass            <= 1'b0;
                        stop_lat        <= stop_on_err;
                        aborted         <= 1'b0;
                        dut_in          <= '0;
                        busy            <= 1'b1;
                    end
                end
                SETTLE_W: begin
                    if (abort)
                        aborted <= 1'b1;
                end
                SAMPLE: begin
                    // an abort here drops the pending sample entirely
                    if (abort) begin
                        aborted <= 1'b1;
                    end else begin
                        smp_valid <= 1'b1;
                        smp_vec   <= dut_in;
                        smp_val   <= dut_out;
                        if (mismatch) begin
                            if (err_cnt != ERR_MAX)
                                err_cnt <= err_cnt + 1'b1;
                            if (!first_err_valid) begin
                                first_err_vec   <= dut_in;
                                first_err_valid <= 1'b1;
                            end
                        end
                        if (state_nxt == SETTLE_W)
                            dut_in <= dut_in + 1'b1;
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_cnt == '0) && !aborted;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_sweep_checker.sv
// Randomised self-checking bench: an OAI221 cell model with injectable faults, plus a
// NAND2 instance, checked against sweep outcomes derived from the cell's boolean function.
module tb_cell_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, stop_on_err = 1'b0;
    logic [4:0]  dut_in;
    logic        dut_out;
    logic        busy, done, pass, first_err_valid, smp_valid, smp_val;
    logic [5:0]  err_cnt;
    logic [4:0]  first_err_vec, smp_vec;

    logic        start2 = 1'b0;
    logic [1:0]  dut_in2;
    logic        dut_out2;
    logic        busy2, done2, pass2, fev2, smp_valid2, smp_val2;
    logic [2:0]  err_cnt2;
    logic [1:0]  first_err_vec2, smp_vec2;

    logic [31:0] flip_mask = '0;
    logic        stuck0 = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int smp_q[$];
    int val_q[$];
    int smp2_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic oai221(input int v);
        logic a, b1, b2, c1, c2;
        a = v[4]; b1 = v[3]; b2 = v[2]; c1 = v[1]; c2 = v[0];
        return !((b1 | b2) & (c1 | c2) & a);
    endfunction

    assign dut_out  = stuck0 ? 1'b0 : (oai221(int'(dut_in)) ^ flip_mask[dut_in]);
    assign dut_out2 = !(dut_in2[1] & dut_in2[0]);

    cell_sweep_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stop_on_err(stop_on_err),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_vec(first_err_vec), .first_err_valid(first_err_valid),
        .smp_valid(smp_valid), .smp_vec(smp_vec), .smp_val(smp_val)
    );

    cell_sweep_checker #(.N_IN(2), .SETTLE(1), .EXP_TT(4'b0111)) u_nand (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .stop_on_err(1'b0),
        .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .first_err_vec(first_err_vec2), .first_err_valid(fev2),
        .smp_valid(smp_valid2), .smp_vec(smp_vec2), .smp_val(smp_val2)
    );

    always @(negedge clk) begin
        if (smp_valid) begin
            smp_q.push_back(int'(smp_vec));
            val_q.push_back(int'(smp_val));
        end
        if (smp_valid2) smp2_cnt++;
    end

    task automatic kick(input logic soe);
        smp_q.delete();
        val_q.delete();
        @(negedge clk);
        start = 1'b1;
        stop_on_err = soe;
        @(negedge clk);
        start = 1'b0;
    endtask

    // counts rising edges after the start edge until done is seen
    task automatic wait_done(output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL done_timeout: no done within %0d cycles", cyc); end
    endtask

    task automatic wait_vec(input int v);
        bit hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (int'(dut_in) == v) hit = 1'b1;
        end
        n_chk++;
        if (!hit) begin n_fail++; $display("FAIL wait_vec: dut_in never reached %0d", v); end
    endtask

    task automatic test_reset();
        #3;
        n_chk++;
        if ({busy, done, pass, first_err_valid, smp_valid, smp_val} !== 6'b0 ||
            dut_in !== 5'd0 || err_cnt !== 6'd0 || first_err_vec !== 5'd0 || smp_vec !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b dut_in=%0d err=%0d fev=%0d got nonzero, want all 0",
                     busy, done, pass, dut_in, err_cnt, first_err_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_golden();
        int cyc; bit ok; bit seq_ok = 1'b1;
        flip_mask = '0; stuck0 = 1'b0;
        kick(1'b0);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL golden_busy: got %b want 1", busy); end
        wait_done(cyc, ok);
        n_chk++;
        if (cyc != 97) begin n_fail++; $display("FAIL golden_latency: got %0d want 97", cyc); end
        n_chk++;
        if (smp_q.size() != 32) begin n_fail++; $display("FAIL golden_samples: got %0d want 32", smp_q.size()); end
        for (int i = 0; i < smp_q.size(); i++)
            if (smp_q[i] != i || val_q[i] != int'(oai221(i))) seq_ok = 1'b0;
        n_chk++;
        if (!seq_ok) begin n_fail++; $display("FAIL golden_sequence: sample order/value wrong, want vec 0..31"); end
        n_chk++;
        if (pass !== 1'b1 || err_cnt !== 6'd0 || first_err_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL golden_result: pass=%b err=%0d fev_valid=%b busy=%b want 1/0/0/0", pass, err_cnt, first_err_valid, busy);
        end
        repeat (5) @(negedge clk);
        n_chk++;
        if (pass !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL golden_hold: pass=%b done=%b want 1/0", pass, done); end
    endtask

    task automatic test_inv5();
        int cyc; bit ok;
        flip_mask = 32'h0000_0020; stuck0 = 1'b0;
        kick(1'b0);
        wait_done(cyc, ok);
        n_chk++;
        if (err_cnt !== 6'd1 || first_err_vec !== 5'd5 || first_err_valid !== 1'b1 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL inv5_result: err=%0d fev=%0d valid=%b pass=%b want 1/5/1/0", err_cnt, first_err_vec, first_err_valid, pass);
        end
    endtask

    task automatic test_stuck0(input logic soe);
        int cyc; bit ok;
        flip_mask = '0; stuck0 = 1'b1;
        kick(soe);
        wait_done(cyc, ok);
        n_chk++;
        if (!soe && (err_cnt !== 6'd23 || first_err_vec !== 5'd0 || smp_q.size() != 32)) begin
            n_fail++;
            $display("FAIL stuck0_full: err=%0d fev=%0d samples=%0d want 23/0/32", err_cnt, first_err_vec, smp_q.size());
        end
        n_chk++;
        if (soe && (err_cnt !== 6'd1 || first_err_vec !== 5'd0 || dut_in !== 5'd0 || smp_q.size() != 1 || cyc != 4)) begin
            n_fail++;
            $display("FAIL stuck0_stop: err=%0d fev=%0d dut_in=%0d samples=%0d cyc=%0d want 1/0/0/1/4",
                     err_cnt, first_err_vec, dut_in, smp_q.size(), cyc);
        end
        stuck0 = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int cyc; bit ok; logic soe;
            int exp_err, first, nsmp, last;
            flip_mask = (it == 0) ? 32'h0 : ($urandom & $urandom);
            soe = 1'(($urandom >> 3) & 1);
            exp_err = 0; first = -1;
            for (int v = 0; v < 32; v++)
                if (flip_mask[v]) begin
                    if (first < 0) first = v;
                    exp_err++;
                end
            if (soe && first >= 0) begin
                exp_err = 1; nsmp = first + 1; last = first;
            end else begin
                nsmp = 32; last = 31;
            end
            kick(soe);
            wait_done(cyc, ok);
            n_chk++;
            if (int'(err_cnt) != exp_err || int'(dut_in) != last || smp_q.size() != nsmp ||
                cyc != nsmp * 3 + 1 || pass !== (exp_err == 0) || first_err_valid !== (first >= 0) ||
                (first >= 0 && int'(first_err_vec) != first)) begin
                n_fail++;
                $display("FAIL random_%0d: mask=%h soe=%b err=%0d/%0d last=%0d/%0d smp=%0d/%0d cyc=%0d/%0d pass=%b fev=%0d/%0d",
                         it, flip_mask, soe, err_cnt, exp_err, dut_in, last, smp_q.size(), nsmp,
                         cyc, nsmp * 3 + 1, pass, first_err_vec, first);
            end
        end
        flip_mask = '0;
    endtask

    task automatic test_abort_and_restart();
        int cyc; bit ok; bit seq_ok = 1'b1;
        flip_mask = '0; stuck0 = 1'b0;
        kick(1'b0);
        wait_vec(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_vec(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(cyc, ok);
        n_chk++;
        if (cyc != 1) begin n_fail++; $display("FAIL abort_latency: got %0d want 1", cyc); end
        for (int i = 0; i < smp_q.size(); i++)
            if (smp_q[i] != i) seq_ok = 1'b0;
        n_chk++;
        if (smp_q.size() != 10 || !seq_ok) begin
            n_fail++; $display("FAIL abort_samples: got %0d samples (in order=%b) want 10 (0..9)", smp_q.size(), seq_ok);
        end
        n_chk++;
        if (pass !== 1'b0 || err_cnt !== 6'd0 || dut_in !== 5'd10) begin
            n_fail++; $display("FAIL abort_result: pass=%b err=%0d dut_in=%0d want 0/0/10", pass, err_cnt, dut_in);
        end
    endtask

    task automatic test_start_with_abort();
        bit seen = 1'b0;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || done || smp_valid) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL start_abort_idle: sweep activity seen, want none"); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        stuck0 = 1'b1;
        kick(1'b0);
        wait_vec(7);
        n_chk++;
        if (err_cnt !== 6'd7) begin n_fail++; $display("FAIL midreset_pre: err=%0d want 7", err_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || dut_in !== 5'd0 || err_cnt !== 6'd0 || first_err_valid !== 1'b0 ||
            smp_valid !== 1'b0 || smp_vec !== 5'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: busy=%b dut_in=%0d err=%0d fev_valid=%b smp_valid=%b smp_vec=%0d want all 0",
                     busy, dut_in, err_cnt, first_err_valid, smp_valid, smp_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stuck0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL midreset_nodone: done/busy seen after reset"); end
    endtask

    task automatic test_nand2();
        int cyc = 0; bit ok = 1'b0;
        smp2_cnt = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done2) ok = 1'b1;
        end
        n_chk++;
        if (!ok || cyc != 9) begin n_fail++; $display("FAIL nand2_latency: got %0d (done=%b) want 9", cyc, ok); end
        n_chk++;
        if (smp2_cnt != 4 || pass2 !== 1'b1 || err_cnt2 !== 3'd0) begin
            n_fail++; $display("FAIL nand2_result: samples=%0d pass=%b err=%0d want 4/1/0", smp2_cnt, pass2, err_cnt2);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_inv5();
        test_stuck0(1'b0);
        test_stuck0(1'b1);
        test_random();
        test_abort_and_restart();
        test_start_with_abort();
        test_reset_mid();
        test_nand2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cell_sweep_checker.md
Name: cell_sweep_checker

Overview:
- Synthesizable, self-checking exhaustive truth-table sweeper for an N-input, single-output combinational cell (OAI/AOI/NAND family).
- Drives every input vector 0..2^N_IN-1 in ascending order, waits a settle interval, samples the cell output and compares it with a parametrised expected truth table.
- Reports error count, first failing vector and pass/fail.
- Sits beside the cell under test in cell-characterisation benches and on-chip cell BIST wrappers.

Parameters:
- N_IN, 5, number of cell inputs; 1..8.
- SETTLE, 2, cycles between driving a vector and sampling; >=1.
- EXP_TT, 32'h111F_FFFF, expected output; bit i = expected output for vector i. The default is OAI221 with vector = {A,B1,B2,C1,C2}, A at the MSB. Width 2^N_IN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  ends the current sweep early.
- stop_on_err  in  1  mode: 1 ends the sweep at the first mismatch. Sampled at start.
- dut_in  out  N_IN  vector driven to the cell.
- dut_out  in  1  cell output.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  valid after done: err_cnt==0 and no abort.
- err_cnt  out  N_IN+1  mismatch count; saturates at 2^N_IN.
- first_err_vec  out  N_IN  first mismatching vector.
- first_err_valid  out  1  first_err_vec holds a valid value.
- smp_valid  out  1  one-cycle strobe for each sampled vector, for logging.
- smp_vec  out  N_IN  vector that was sampled.
- smp_val  out  1  sampled dut_out.

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE.
  - dut_in, err_cnt, first_err_vec = 0.
  - busy, done, pass, first_err_valid, smp_valid, smp_val = 0.
  - smp_vec = 0.
- FSM states: IDLE, SETTLE_W, SAMPLE, FINISH.
- IDLE:
  - start=1 → clear err_cnt, first_err_valid and pass; latch stop_on_err; dut_in=0; settle counter=SETTLE-1; busy=1; go to SETTLE_W.
  - start=1 together with abort=1: abort wins and no sweep begins.
- SETTLE_W:
  - Counter decrements each cycle.
  - At 0 → SAMPLE.
  - dut_in is held stable for exactly SETTLE cycles before sampling.
- SAMPLE (one cycle):
  - Capture dut_out; set smp_valid=1, smp_vec=dut_in, smp_val=dut_out on the next edge.
  - Mismatch (dut_out != EXP_TT[dut_in]):
    - err_cnt++ (saturating).
    - If first_err_valid==0, set first_err_vec=dut_in and first_err_valid=1.
  - If dut_in==2^N_IN-1, or (stop_on_err latched and mismatch): go to FINISH.
  - Otherwise: dut_in++; counter=SETTLE-1; go to SETTLE_W.
- FINISH (one cycle):
  - done=1, busy=0, pass=(err_cnt==0 && !aborted); return to IDLE.
  - dut_in holds the last vector.
- Timing: cycles per vector = SETTLE+1. A full clean sweep asserts done 2^N_IN·(SETTLE+1)+1 cycles after the start edge.
- abort in SETTLE_W or SAMPLE:
  - Next state FINISH; the pending sample is discarded; pass=0.
  - err_cnt and first_err_vec keep their accumulated values.
- start while busy is ignored.
- Results (err_cnt, first_err_*, pass) are held in IDLE until the next start.
- rst_n low mid-sweep: immediate return to the reset values. No done pulse is produced.
- The dut_out sample is a plain register; the cell path is expected to settle within SETTLE cycles. No synchroniser.

Decomposition:
- Shared package cell_tb_pkg:
  - state enum sweep_state_t.
  - Truth-table constants TT_OAI221 (32'h111F_FFFF), TT_NAND2 (4'b0111), TT_AOI21, etc.
  - Function tt_bit(tt, vec).
- One natural sub-module: sweep_settle_cnt, a loadable down-counter with a zero flag.
- Compare and result logic stays in the top module.

Test Plan:
- Golden OAI221 model, SETTLE=2, start pulse → 32 smp_valid strobes, smp_vec 0..31; done at cycle 97; pass=1; err_cnt=0; first_err_valid=0.
- Golden model with output inverted only at vector 5 → err_cnt=1; first_err_vec=5; pass=0.
- Output stuck-at-0, stop_on_err=0 → err_cnt=23; first_err_vec=0; all 32 vectors sampled.
- Output stuck-at-0, stop_on_err=1 → done after the first sample; err_cnt=1; first_err_vec=0; dut_in=0.
- Abort asserted during vector 10 settle → done next cycle; pass=0; no smp_valid for vector 10. A second start during busy is ignored. rst_n pulsed mid-sweep → all outputs return to 0 asynchronously.
- N_IN=2, SETTLE=1, EXP_TT=4'b0111, NAND2 model → 4 samples; done 9 cycles after start; pass=1.
